// File: rtl/clz_norm_arbiter.sv
// Round-robin front end sharing one registered leading-zero counter.
// Each response carries the count, a zero flag and the normalised operand.

// Registered leading-zero counter: vout = operand non-zero, pout = zeros
module clz_clk #(
    parameter int WIDTH = 16,
    localparam int PW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [PW-1:0]    pout
);

    logic          nz;
    logic [PW-1:0] lz;

    // Priority search from the MSB for the first set bit
    always_comb begin
        nz = 1'b0;
        lz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!nz && din[WIDTH-1-i]) begin
                nz = 1'b1;
                lz = PW'(i);
            end
        end
    end

    // Capture the result when enabled; cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vout <= 1'b0;
            pout <= '0;
        end else if (en) begin
            vout <= nz;
            pout <= lz;
        end
    end

endmodule

module clz_norm_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = $clog2(NREQ),
    localparam int PW = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_zero,
    output logic [CW-1:0]         rsp_count,
    output logic [WIDTH-1:0]      rsp_norm
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    last_q;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] op_q;

    logic             grant_any;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;
    logic             accept;

    logic             vout;
    logic [PW-1:0]    pout;

    // Round-robin search starting just after the last granted index
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_q;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_any;

    // One-hot grant, only while idle
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic: accept, one compute cycle, hold response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_any) state_d = BUSY;
            BUSY:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand, requester id and arbitration pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            id_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                id_q   <= grant_idx;
                last_q <= grant_idx;
            end
        end
    end

    clz_clk #(
        .WIDTH (WIDTH)
    ) u_clz (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == BUSY),
        .din  (op_q),
        .vout (vout),
        .pout (pout)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_zero  = ~vout;
    assign rsp_count = vout ? CW'(pout) : CW'(WIDTH);
    assign rsp_norm  = op_q << rsp_count;

endmodule

// File: tb/tb_clz_norm_arbiter.sv
// Bench for clz_norm_arbiter: vector table, directed handshake
// sequences and a randomized run against a reference model.
module tb_clz_norm_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_zero;
    logic [4:0]  rsp_count;
    logic [15:0] rsp_norm;

    always #5 clk = ~clk;

    clz_norm_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_zero  (rsp_zero),
        .rsp_count (rsp_count),
        .rsp_norm  (rsp_norm)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [15:0] opnd;
        logic [4:0]  cnt;
        logic        zero;
        logic [15:0] norm;
    } vec_t;

    typedef struct {
        int          id;
        logic [4:0]  cnt;
        logic        zero;
        logic [15:0] norm;
    } exp_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Count leading zeros by shifting until the top bit is set
    function automatic int ref_count(input logic [15:0] d);
        logic [15:0] v;
        int n;
        v = d;
        n = 0;
        while (n < 16 && v[15] == 1'b0) begin
            v = v << 1;
            n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] ref_norm(input logic [15:0] d);
        int n;
        n = ref_count(d);
        return (n >= 16) ? 16'h0 : d << n;
    endfunction

    // Winner is the valid requester with the smallest distance past last
    function automatic int rr_pick(input logic [3:0] v, input int last);
        int best;
        int bd;
        int d;
        best = -1;
        bd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                d = (i - last - 1 + NREQ) % NREQ;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
    endtask

    task automatic do_op(input vec_t v);
        req_valid = 4'(1 << v.id);
        req_data[v.id*WIDTH +: WIDTH] = v.opnd;
        #1;
        chk("op_grant", req_ready, 1 << v.id);
        @(posedge clk);
        #1 req_valid = '0;
        #1;
        chk("op_busy_ready", req_ready, 0);
        chk("op_busy_valid", rsp_valid, 0);
        @(posedge clk);
        #2;
        chk("op_rsp_valid", rsp_valid, 1);
        chk("op_rsp_id", rsp_id, v.id);
        chk("op_rsp_count", rsp_count, v.cnt);
        chk("op_rsp_zero", rsp_zero, v.zero);
        chk("op_rsp_norm", rsp_norm, v.norm);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        #1;
        chk("op_done_valid", rsp_valid, 0);
    endtask

    task automatic drain(input int exp_id);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        chk("drain_seen", got, 1);
        if (got) begin
            chk("drain_id", rsp_id, exp_id);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            #1;
        end
    endtask

    logic [3:0]  pend;
    logic [15:0] pdata[4];
    int          last_m;
    int          others[4];
    int          cyc;
    int          acc_cyc;
    int          n_acc;
    exp_t        sbq[$];

    task automatic rand_cycle(input bit gen);
        logic [15:0] d;
        logic [3:0]  exp_rdy;
        logic [3:0]  hit;
        exp_t        e;
        int          g;
        for (int i = 0; i < NREQ; i++) begin
            if (gen && !pend[i] && $urandom_range(0, 2) == 0) begin
                case ($urandom % 8)
                    0: d = 16'h0;
                    1: d = 16'h8000 >> ($urandom % 16);
                    default: d = 16'($urandom) >> ($urandom % 16);
                endcase
                pend[i] = 1'b1;
                pdata[i] = d;
                req_data[i*WIDTH +: WIDTH] = d;
                others[i] = 0;
            end
        end
        req_valid = pend;
        rsp_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        exp_rdy = '0;
        if (sbq.size() == 0 && pend != 0)
            exp_rdy = 4'(1 << rr_pick(pend, last_m));
        chk("rnd_req_ready", req_ready, exp_rdy);
        chk("rnd_rsp_valid", rsp_valid,
            (sbq.size() > 0) && (cyc - acc_cyc >= 2));
        if (rsp_valid && rsp_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rnd_rsp_id", rsp_id, e.id);
            chk("rnd_rsp_count", rsp_count, e.cnt);
            chk("rnd_rsp_zero", rsp_zero, e.zero);
            chk("rnd_rsp_norm", rsp_norm, e.norm);
        end
        hit = req_ready & req_valid;
        if (hit != 0) begin
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--)
                if (hit[i]) g = i;
            e.id = g;
            e.cnt = 5'(ref_count(pdata[g]));
            e.zero = (pdata[g] == 16'h0);
            e.norm = ref_norm(pdata[g]);
            sbq.push_back(e);
            acc_cyc = cyc;
            n_acc++;
            for (int j = 0; j < NREQ; j++) begin
                if (j != g && pend[j]) begin
                    others[j]++;
                    chk("rnd_starve", others[j] <= 3, 1);
                end
            end
            others[g] = 0;
            pend[g] = 1'b0;
            last_m = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gi[$];
        int   gc[$];
        int   ord[6];
        logic [1:0]  h_id;
        logic [4:0]  h_cnt;
        logic        h_zero;
        logic [15:0] h_norm;

        vecs[0] = '{2, 16'h0010, 5'd11, 1'b0, 16'h8000};
        vecs[1] = '{0, 16'h0000, 5'd16, 1'b1, 16'h0000};
        vecs[2] = '{1, 16'h8000, 5'd0,  1'b0, 16'h8000};
        vecs[3] = '{3, 16'h0001, 5'd15, 1'b0, 16'h8000};
        vecs[4] = '{0, 16'h1234, 5'd3,  1'b0, 16'h91A0};
        vecs[5] = '{1, 16'h00FF, 5'd8,  1'b0, 16'hFF00};
        vecs[6] = '{2, 16'h0F0F, 5'd4,  1'b0, 16'hF0F0};
        vecs[7] = '{3, 16'h7FFF, 5'd1,  1'b0, 16'hFFFE};

        req_data = '0;
        do_reset();

        for (int k = 0; k < 8; k++) do_op(vecs[k]);

        // All four requesting, consumer always ready
        do_reset();
        for (int i = 0; i < NREQ; i++)
            req_data[i*WIDTH +: WIDTH] = 16'(16'h0100 << i);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            chk("t3_onehot", $countones(req_ready) <= 1, 1);
            for (int j = 0; j < NREQ; j++) begin
                if (req_ready[j]) begin
                    gi.push_back(j);
                    gc.push_back(c);
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("t3_grants", gi.size(), 6);
        ord = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6 && k < gi.size(); k++) begin
            chk("t3_order", gi[k], ord[k]);
            if (k > 0) chk("t3_spacing", gc[k] - gc[k-1], 3);
        end

        // Back-pressure in RESP with requests waiting (last grant was 1)
        req_data[2*WIDTH +: WIDTH] = 16'h0300;
        req_valid = 4'b0100;
        #1;
        chk("t4_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid = 4'b1010;
        #1;
        chk("t4_busy_ready", req_ready, 0);
        @(posedge clk);
        #2;
        chk("t4_valid", rsp_valid, 1);
        chk("t4_id", rsp_id, 2);
        chk("t4_count", rsp_count, 6);
        chk("t4_norm", rsp_norm, 16'hC000);
        h_id = rsp_id;
        h_cnt = rsp_count;
        h_zero = rsp_zero;
        h_norm = rsp_norm;
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_ready", req_ready, 0);
            chk("t4_hold_id", rsp_id, h_id);
            chk("t4_hold_count", rsp_count, h_cnt);
            chk("t4_hold_zero", rsp_zero, h_zero);
            chk("t4_hold_norm", rsp_norm, h_norm);
            @(posedge clk);
            #2;
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_release_valid", rsp_valid, 1);
        chk("t4_release_ready", req_ready, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        #1;
        chk("t4_next_grant", req_ready, 4'b1000);
        @(posedge clk);
        #1 req_valid = '0;
        #1;
        drain(3);

        // Reset while BUSY discards the operation and the pointer
        req_data[1*WIDTH +: WIDTH] = 16'h00F0;
        req_valid = 4'b0010;
        #1;
        chk("t5_grant1", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t5_no_rsp", rsp_valid, 0);
            @(posedge clk);
            #1;
        end
        req_data[0 +: WIDTH] = 16'h0004;
        req_valid = 4'b1001;
        #1;
        chk("t5_grant0", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        #1;
        drain(0);
        chk("t5_count", rsp_count, 13);

        // Randomized traffic against the reference model
        do_reset();
        pend = '0;
        last_m = NREQ - 1;
        cyc = 0;
        acc_cyc = 0;
        n_acc = 0;
        for (int i = 0; i < NREQ; i++) begin
            others[i] = 0;
            pdata[i] = '0;
        end
        for (int c = 0; c < 10000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 40; c++) rand_cycle(1'b0);
        chk("rnd_sb_empty", sbq.size(), 0);
        chk("rnd_pend_empty", pend, 0);
        chk("rnd_activity", n_acc > 500, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
